// File: rtl/axi_sram_slave.sv
// AXI4 slave terminating a 64-bit master on on-chip SRAM; one burst at a time,
// AW/AR round-robin arbitration, OKAY/SLVERR/DECERR decode per burst.
module axi_sram_slave #(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned ID_W      = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [ID_W-1:0] awid_i,
    input  logic [31:0]     awaddr_i,
    input  logic [7:0]      awlen_i,
    input  logic [2:0]      awsize_i,
    input  logic [1:0]      awburst_i,
    input  logic            awvalid_i,
    output logic            awready_o,
    input  logic [63:0]     wdata_i,
    input  logic [7:0]      wstrb_i,
    input  logic            wlast_i,
    input  logic            wvalid_i,
    output logic            wready_o,
    output logic [ID_W-1:0] bid_o,
    output logic [1:0]      bresp_o,
    output logic            bvalid_o,
    input  logic            bready_i,
    input  logic [ID_W-1:0] arid_i,
    input  logic [31:0]     araddr_i,
    input  logic [7:0]      arlen_i,
    input  logic [2:0]      arsize_i,
    input  logic [1:0]      arburst_i,
    input  logic            arvalid_i,
    output logic            arready_o,
    output logic [ID_W-1:0] rid_o,
    output logic [63:0]     rdata_o,
    output logic [1:0]      rresp_o,
    output logic            rlast_o,
    output logic            rvalid_o,
    input  logic            rready_i
);

    localparam int unsigned MEM_AW = $clog2(MEM_BYTES);
    localparam int unsigned IDX_W  = MEM_AW - 3;
    localparam int unsigned WORDS  = MEM_BYTES / 8;
    localparam logic [40:0] MEM_TOP = 41'(MEM_BASE) + 41'(MEM_BYTES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WDATA = 2'd1;
    localparam logic [1:0] ST_WRESP = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    logic [1:0]      state_q, state_d;
    logic            rr_pref_q, rr_pref_d;    // 1: write preferred on contention
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [2:0]      size_q, size_d;
    logic [1:0]      burst_q, burst_d;
    logic [7:0]      beat_q, beat_d;
    logic [1:0]      resp_q, resp_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic            rvalid_q, rvalid_d;
    logic            rlast_q, rlast_d;
    logic [63:0]     rdata_q, rdata_d;

    logic            grant_w, grant_r;
    logic            awready_c, arready_c;
    logic            rd_launch;
    logic [31:0]     rd_addr;
    logic [1:0]      rd_resp;
    logic            mem_we;

    logic [63:0]     mem_q [WORDS];

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - MEM_BASE) >> 3);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == BURST_INCR) ? a + (32'd1 << size) : a;
    endfunction

    // Burst-level decode: range check over the whole burst footprint first.
    function automatic logic [1:0] calc_resp(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
        logic [40:0] beats;
        logic [40:0] last;
        beats = (burst == BURST_INCR) ? 41'(len) + 41'd1 : 41'd1;
        last  = 41'(a) + (beats << size);
        if (a < MEM_BASE || last > MEM_TOP) return RESP_DECERR;
        if ((burst != BURST_FIXED && burst != BURST_INCR) || size > 3'd3) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    always_comb begin
        state_d   = state_q;
        rr_pref_d = rr_pref_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        resp_d    = resp_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rd_launch = 1'b0;
        rd_addr   = addr_q;
        rd_resp   = resp_q;
        mem_we    = 1'b0;
        awready_c = 1'b0;
        arready_c = 1'b0;
        grant_w   = awvalid_i && (!arvalid_i || rr_pref_q);
        grant_r   = arvalid_i && !grant_w;

        case (state_q)
            ST_IDLE: begin
                awready_c = grant_w;
                arready_c = grant_r;
                if (awvalid_i && arvalid_i) rr_pref_d = !rr_pref_q;
                if (grant_w) begin
                    id_d     = awid_i;
                    addr_d   = awaddr_i;
                    len_d    = awlen_i;
                    size_d   = awsize_i;
                    burst_d  = awburst_i;
                    beat_d   = 8'd0;
                    resp_d   = calc_resp(awaddr_i, awlen_i, awsize_i, awburst_i);
                    wready_d = 1'b1;
                    state_d  = ST_WDATA;
                end else if (grant_r) begin
                    id_d      = arid_i;
                    len_d     = arlen_i;
                    size_d    = arsize_i;
                    burst_d   = arburst_i;
                    beat_d    = 8'd0;
                    resp_d    = calc_resp(araddr_i, arlen_i, arsize_i, arburst_i);
                    rd_launch = 1'b1;
                    rd_addr   = araddr_i;
                    rd_resp   = resp_d;
                    addr_d    = next_addr(araddr_i, arsize_i, arburst_i);
                    rlast_d   = (arlen_i == 8'd0);
                    rvalid_d  = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_WDATA: begin
                if (wvalid_i && wready_q) begin
                    mem_we = (resp_q == RESP_OKAY);
                    if ((wlast_i != (beat_q == len_q)) && resp_q != RESP_DECERR)
                        resp_d = RESP_SLVERR;
                    addr_d = next_addr(addr_q, size_q, burst_q);
                    if (beat_q == len_q) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        state_d  = ST_WRESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_WRESP: begin
                if (bready_i) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (rready_i) begin
                    if (beat_q == len_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        rdata_d  = 64'd0;
                        state_d  = ST_IDLE;
                    end else begin
                        // Prefetch the next beat so rready=1 streams one beat per clock.
                        beat_d    = beat_q + 8'd1;
                        rd_launch = 1'b1;
                        rd_addr   = addr_q;
                        addr_d    = next_addr(addr_q, size_q, burst_q);
                        rlast_d   = ((beat_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_launch) rdata_d = (rd_resp == RESP_OKAY) ? mem_q[word_idx(rd_addr)] : 64'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            rr_pref_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'd0;
            beat_q    <= 8'd0;
            resp_q    <= RESP_OKAY;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 64'd0;
        end else begin
            state_q   <= state_d;
            rr_pref_q <= rr_pref_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            resp_q    <= resp_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
        end
    end

    // SRAM array is not reset; contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb_i[i]) mem_q[word_idx(addr_q)][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign awready_o = awready_c;
    assign arready_o = arready_c;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bid_o     = id_q;
    assign bresp_o   = resp_q;
    assign rvalid_o  = rvalid_q;
    assign rid_o     = id_q;
    assign rresp_o   = resp_q;
    assign rlast_o   = rlast_q;
    assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: scoreboard queues of expected B/R responses,
// reference memory model for read data.
module tb_axi_sram_slave;

    localparam int unsigned ID_W = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
    localparam logic [1:0]  DECERR = 2'b11;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [ID_W-1:0] awid_i = '0, arid_i = '0;
    logic [31:0]     awaddr_i = '0, araddr_i = '0;
    logic [7:0]      awlen_i = '0, arlen_i = '0;
    logic [2:0]      awsize_i = '0, arsize_i = '0;
    logic [1:0]      awburst_i = '0, arburst_i = '0;
    logic            awvalid_i = 1'b0, arvalid_i = 1'b0;
    logic [63:0]     wdata_i = '0;
    logic [7:0]      wstrb_i = '0;
    logic            wlast_i = 1'b0, wvalid_i = 1'b0;
    logic            bready_i = 1'b0, rready_i = 1'b0;
    logic            awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o;
    logic [ID_W-1:0] bid_o, rid_o;
    logic [1:0]      bresp_o, rresp_o;
    logic [63:0]     rdata_o;

    always #5 clk_i = ~clk_i;

    axi_sram_slave #(.MEM_BASE(BASE), .MEM_BYTES(65536), .ID_W(ID_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
        .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i),
        .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
        .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i)
    );

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
        logic [1:0]      resp;
        logic            last;
    } rbeat_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } bexp_t;

    rbeat_t      rq[$];
    bexp_t       bq[$];
    logic [63:0] wq[$];
    logic [63:0] mem_m [int];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic aw_phase(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
        awvalid_i = 1'b1;
        @(negedge clk_i);
        while (!awready_o && n < 50) begin n++; @(negedge clk_i); end
        chk("aw_ready", 64'(awready_o), 64'd1);
        @(posedge clk_i); #1;
        awvalid_i = 1'b0;
    endtask

    task automatic ar_phase(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst;
        arvalid_i = 1'b1;
        @(negedge clk_i);
        while (!arready_o && n < 50) begin n++; @(negedge clk_i); end
        chk("ar_ready", 64'(arready_o), 64'd1);
        @(posedge clk_i); #1;
        arvalid_i = 1'b0;
    endtask

    task automatic w_data(input int len, input logic [7:0] strb, input int badlast);
        for (int i = 0; i <= len; i++) begin
            int n = 0;
            wdata_i = wq[i];
            wstrb_i = strb;
            wlast_i = (badlast < 0) ? (i == len) : (i == badlast);
            wvalid_i = 1'b1;
            @(negedge clk_i);
            while (!wready_o && n < 50) begin n++; @(negedge clk_i); end
            chk("w_ready", 64'(wready_o), 64'd1);
            @(posedge clk_i); #1;
        end
        wvalid_i = 1'b0;
        wlast_i = 1'b0;
    endtask

    task automatic b_recv();
        bexp_t e;
        int n = 0;
        e = bq.pop_front();
        bready_i = 1'b1;
        @(negedge clk_i);
        while (!bvalid_o && n < 50) begin n++; @(negedge clk_i); end
        chk("b_latency", 64'(n), 64'd0);
        chk("bid", 64'(bid_o), 64'(e.id));
        chk("bresp", 64'(bresp_o), 64'(e.resp));
        @(posedge clk_i); #1;
        bready_i = 1'b0;
        chk("b_drop", 64'(bvalid_o), 64'd0);
    endtask

    // mode 0: rready held high (gapless check); mode 1: rready toggles 1-0-1.
    task automatic rd_collect(input int mode);
        rbeat_t e;
        int cyc = 0;
        while (rq.size() > 0 && cyc < 2000) begin
            rready_i = (mode == 0) || (cyc % 3 != 1);
            @(negedge clk_i);
            if (mode == 0) chk("r_gapless", 64'(rvalid_o), 64'd1);
            if (rvalid_o) begin
                e = rq[0];
                chk("rdata", rdata_o, e.data);
                chk("rresp", 64'(rresp_o), 64'(e.resp));
                chk("rlast", 64'(rlast_o), 64'(e.last));
                chk("rid", 64'(rid_o), 64'(e.id));
                if (rready_i) void'(rq.pop_front());
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        rready_i = 1'b0;
        chk("r_pending", 64'(rq.size()), 64'd0);
        chk("r_drop", 64'(rvalid_o), 64'd0);
    endtask

    task automatic push_r(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] resp);
        int k = int'((addr - BASE) >> 3);
        for (int i = 0; i <= len; i++)
            rq.push_back('{id, (resp == OKAY) ? mem_m[k + i] : 64'd0, resp, (i == len)});
    endtask

    task automatic model_write(input logic [31:0] addr, input int len, input logic [7:0] strb);
        int k = int'((addr - BASE) >> 3);
        for (int i = 0; i <= len; i++) begin
            logic [63:0] v = mem_m.exists(k + i) ? mem_m[k + i] : 64'd0;
            for (int b = 0; b < 8; b++) if (strb[b]) v[8*b +: 8] = wq[i][8*b +: 8];
            mem_m[k + i] = v;
        end
    endtask

    task automatic wr_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [7:0] strb, input int badlast,
                            input logic [1:0] exp_resp);
        aw_phase(id, addr, len, size, 2'b01);
        w_data(int'(len), strb, badlast);
        if (exp_resp == OKAY) model_write(addr, int'(len), strb);
        bq.push_back('{id, exp_resp});
        b_recv();
    endtask

    task automatic rd_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp,
                            input int mode);
        ar_phase(id, addr, len, size, burst);
        push_r(id, addr, int'(len), exp_resp);
        rd_collect(mode);
    endtask

    initial begin
        #2;
        chk("rst_awready", 64'(awready_o), 64'd0);
        chk("rst_wready", 64'(wready_o), 64'd0);
        chk("rst_bvalid", 64'(bvalid_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        #10 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Contention from IDLE after reset: write wins, read follows B.
        wq = {64'h0123_4567_89AB_CDEF};
        awid_i = 4'd1; awaddr_i = BASE + 32'h200; awlen_i = 8'd0; awsize_i = 3'd3; awburst_i = 2'b01;
        arid_i = 4'd2; araddr_i = BASE + 32'h200; arlen_i = 8'd0; arsize_i = 3'd3; arburst_i = 2'b01;
        awvalid_i = 1'b1; arvalid_i = 1'b1;
        @(negedge clk_i);
        chk("arb1_aw", 64'(awready_o), 64'd1);
        chk("arb1_ar", 64'(arready_o), 64'd0);
        @(posedge clk_i); #1;
        awvalid_i = 1'b0;
        w_data(0, 8'hFF, -1);
        model_write(BASE + 32'h200, 0, 8'hFF);
        bq.push_back('{4'd1, OKAY});
        chk("arb1_ar_wait", 64'(arready_o), 64'd0);
        b_recv();
        @(negedge clk_i);
        chk("arb1_ar_after_b", 64'(arready_o), 64'd1);
        @(posedge clk_i); #1;
        arvalid_i = 1'b0;
        push_r(4'd2, BASE + 32'h200, 0, OKAY);
        rd_collect(0);

        // Contention again: read now preferred.
        wq = {64'hFEDC_BA98_7654_3210};
        awid_i = 4'd3; awaddr_i = BASE + 32'h208;
        arid_i = 4'd4; araddr_i = BASE + 32'h200;
        awvalid_i = 1'b1; arvalid_i = 1'b1;
        @(negedge clk_i);
        chk("arb2_ar", 64'(arready_o), 64'd1);
        chk("arb2_aw", 64'(awready_o), 64'd0);
        @(posedge clk_i); #1;
        arvalid_i = 1'b0;
        push_r(4'd4, BASE + 32'h200, 0, OKAY);
        rd_collect(0);
        aw_phase(4'd3, BASE + 32'h208, 8'd0, 3'd3, 2'b01);
        w_data(0, 8'hFF, -1);
        model_write(BASE + 32'h208, 0, 8'hFF);
        bq.push_back('{4'd3, OKAY});
        b_recv();

        // Basic 4-beat write/read.
        wq = {64'd1, 64'd2, 64'd3, 64'd4};
        wr_burst(4'd5, BASE, 8'd3, 3'd3, 8'hFF, -1, OKAY);
        rd_burst(4'd6, BASE, 8'd3, 3'd3, 2'b01, OKAY, 0);

        // Partial strobe.
        wq = {64'hFFFF_FFFF_FFFF_FFFF};
        wr_burst(4'd7, BASE + 32'h10, 8'd0, 3'd3, 8'hFF, -1, OKAY);
        wq = {64'h1122_3344_5566_7788};
        wr_burst(4'd7, BASE + 32'h10, 8'd0, 3'd3, 8'h0F, -1, OKAY);
        ar_phase(4'd8, BASE + 32'h10, 8'd0, 3'd3, 2'b01);
        rq.push_back('{4'd8, 64'hFFFF_FFFF_5566_7788, OKAY, 1'b1});
        rd_collect(0);

        // Decode errors and boundaries.
        wq = {64'hA5A5_A5A5_A5A5_A5A5};
        wr_burst(4'd9, BASE + 32'hFFF8, 8'd0, 3'd3, 8'hFF, -1, OKAY);
        rd_burst(4'd1, 32'h7FFF_FFF8, 8'd1, 3'd3, 2'b01, DECERR, 0);
        wq = {64'd0, 64'd0};
        wr_burst(4'd2, 32'h7FFF_FFF8, 8'd1, 3'd3, 8'hFF, -1, DECERR);
        rd_burst(4'd3, BASE + 32'hFFF8, 8'd0, 3'd3, 2'b01, OKAY, 0);
        rd_burst(4'd4, BASE + 32'hFFF8, 8'd1, 3'd3, 2'b01, DECERR, 0);
        rd_burst(4'd5, BASE, 8'd0, 3'd4, 2'b01, SLVERR, 0);
        rd_burst(4'd6, BASE, 8'd3, 3'd3, 2'b10, SLVERR, 0);

        // Backpressure on an 8-beat read, then full-rate.
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back({$urandom(), $urandom()});
        wr_burst(4'd10, BASE + 32'h100, 8'd7, 3'd3, 8'hFF, -1, OKAY);
        rd_burst(4'd11, BASE + 32'h100, 8'd7, 3'd3, 2'b01, OKAY, 1);
        rd_burst(4'd12, BASE + 32'h100, 8'd7, 3'd3, 2'b01, OKAY, 0);

        // Maximum burst length.
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(64'(i) * 64'h0101_0101 + 64'd7);
        wr_burst(4'd13, BASE + 32'h1000, 8'd255, 3'd3, 8'hFF, -1, OKAY);
        rd_burst(4'd14, BASE + 32'h1000, 8'd255, 3'd3, 2'b01, OKAY, 0);

        // Early wlast.
        wq = {64'd11, 64'd12, 64'd13, 64'd14};
        wr_burst(4'd15, BASE + 32'h300, 8'd3, 3'd3, 8'hFF, 2, SLVERR);

        // Reset mid read burst.
        ar_phase(4'd6, BASE, 8'd7, 3'd3, 2'b01);
        rready_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        rready_i = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("mid_rst_rdata", rdata_o, 64'd0);
        chk("mid_rst_rlast", 64'(rlast_o), 64'd0);
        chk("mid_rst_rid", 64'(rid_o), 64'd0);
        rq.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        rd_burst(4'd7, BASE, 8'd3, 3'd3, 2'b01, OKAY, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
